// File: rtl/rojo_upd_handshake.sv
// Rojobot update handshake: brings the asynchronous update strobe into HCLK,
// snapshots BotInfo per update and holds an interrupt flag until the CPU acknowledges it.
module rojo_upd_handshake #(
    parameter int SYNC_STAGES = 2,
    parameter int MISS_W      = 8,
    parameter int UPD_W       = 16
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              bot_upd_async,
    input  logic [31:0]       bot_info_in,
    input  logic              int_ack,
    input  logic              clr_cnt,
    output logic              bot_upd_sync,
    output logic [31:0]       bot_info_snap,
    output logic [UPD_W-1:0]  upd_cnt,
    output logic [MISS_W-1:0] miss_cnt,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_ACKED = 2'd2
    } state_t;

    function automatic logic [MISS_W-1:0] sat_inc(input logic [MISS_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_prev_q;
    logic                   int_ack_q;
    state_t                 state_q, state_d;
    logic                   deferred_q, deferred_d;
    logic                   flag_q, busy_q;
    logic [31:0]            snap_q, snap_d;
    logic [UPD_W-1:0]       upd_cnt_q, upd_cnt_d;
    logic [MISS_W-1:0]      miss_cnt_q, miss_cnt_d;

    logic upd_edge;
    logic ack_rise;
    logic miss_inc;

    // Synchronizer input side and edge/acknowledge detection
    assign sync_d   = {sync_q[SYNC_STAGES-2:0], bot_upd_async};
    assign upd_edge = sync_q[SYNC_STAGES-1] & ~s_prev_q;
    assign ack_rise = int_ack & ~int_ack_q;

    always_comb begin
        state_d    = state_q;
        deferred_d = deferred_q;
        miss_inc   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // An update while the CPU still holds int_ack high must wait for
                // the release, otherwise the flag would rise under a stale ack.
                if (upd_edge) begin
                    if (int_ack) begin
                        state_d    = ST_ACKED;
                        deferred_d = 1'b1;
                    end else begin
                        state_d = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if (ack_rise) begin
                    state_d    = ST_ACKED;
                    deferred_d = upd_edge;
                end else if (upd_edge) begin
                    miss_inc = 1'b1;
                end
            end
            ST_ACKED: begin
                if (upd_edge) begin
                    if (deferred_q) begin
                        miss_inc = 1'b1;
                    end else begin
                        deferred_d = 1'b1;
                    end
                end
                if (!int_ack) begin
                    state_d    = (deferred_q || upd_edge) ? ST_PEND : ST_IDLE;
                    deferred_d = 1'b0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                deferred_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        snap_d     = snap_q;
        upd_cnt_d  = upd_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (upd_edge) begin
            snap_d = bot_info_in;
        end
        if (clr_cnt) begin
            upd_cnt_d  = '0;
            miss_cnt_d = '0;
        end else begin
            if (upd_edge) begin
                upd_cnt_d = upd_cnt_q + 1'b1;
            end
            if (miss_inc) begin
                miss_cnt_d = sat_inc(miss_cnt_q);
            end
        end
    end

    // State, counters and output registers
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            sync_q     <= '0;
            s_prev_q   <= 1'b0;
            int_ack_q  <= 1'b0;
            state_q    <= ST_IDLE;
            deferred_q <= 1'b0;
            flag_q     <= 1'b0;
            busy_q     <= 1'b0;
            snap_q     <= '0;
            upd_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            sync_q     <= sync_d;
            s_prev_q   <= sync_q[SYNC_STAGES-1];
            int_ack_q  <= int_ack;
            state_q    <= state_d;
            deferred_q <= deferred_d;
            flag_q     <= (state_d == ST_PEND);
            busy_q     <= (state_d != ST_IDLE);
            snap_q     <= snap_d;
            upd_cnt_q  <= upd_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign bot_upd_sync  = flag_q;
    assign bot_info_snap = snap_q;
    assign upd_cnt       = upd_cnt_q;
    assign miss_cnt      = miss_cnt_q;
    assign busy          = busy_q;

endmodule
